uart_tx_buffer: RTL and testbench

Transmit-side byte queue and launch controller that sits directly upstream of the UART transmitter. Software/bus logic pushes bytes with a single-cycle write strobe. The block stores them in a circular FIFO and feeds them one at a time to the transmitter via a tx_start pulse plus a held tx_data byte. It advances to the next byte only after the transmitter's tx_done_tick.

---
 rtl/uart_tx_buffer_if.sv | 43 ++++
 rtl/uart_tx_buffer.sv | 147 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_if.sv
// rtl/uart_tx_buffer_if.sv - byte push and transmitter launch signals for uart_tx_buffer
//
// Purpose: bundles the push side (wr_en/wr_data/full/empty/count/busy) and
// the transmitter side (tx_start/tx_data/tx_done_tick) of the transmit buffer.
// The slave modport is the buffer; the master modport is whoever pushes bytes
// and owns the transmitter.
// Optional macro UART_TX_BUFFER_OVERFLOW_FLAG_EN adds ovf_clr and overflow.
interface uart_tx_buffer_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  busy;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_done_tick;
`ifdef UART_TX_BUFFER_OVERFLOW_FLAG_EN
  logic                  ovf_clr;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, tx_done_tick, ovf_clr,
    input  full, empty, count, busy, tx_start, tx_data, overflow
  );
  modport slave (
    input  wr_en, wr_data, tx_done_tick, ovf_clr,
    output full, empty, count, busy, tx_start, tx_data, overflow
  );
`else
  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, count, busy, tx_start, tx_data
  );
  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, count, busy, tx_start, tx_data
  );
`endif
endinterface

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - transmit byte FIFO and launch controller for a UART transmitter
//
// Purpose: stores pushed bytes in a circular FIFO and hands them one at a
// time to the transmitter with a one-cycle tx_start pulse, holding tx_data
// until the transmitter returns tx_done_tick.
// Ports:
//   clk                 system clock, all state on rising edge
//   reset               asynchronous active-high reset
//   bus.wr_en/wr_data   push strobe and byte (dropped while full)
//   bus.full/empty      registered occupancy flags
//   bus.count           registered occupancy, 0..2^DEPTH_LOG2
//   bus.busy            FIFO non-empty or a byte still in flight
//   bus.tx_start        one-cycle launch pulse to the transmitter
//   bus.tx_data         byte in flight, held from tx_start until tx_done_tick
//   bus.tx_done_tick    completion pulse from the transmitter
// Optional macro UART_TX_BUFFER_OVERFLOW_FLAG_EN adds bus.ovf_clr (input)
// and bus.overflow (sticky output, set by a push attempted while full).
module uart_tx_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_buffer_if.slave bus
);
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [1:0]            state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  push;
  logic                  pop;

  always_comb begin
    // A push is judged against the registered full flag, so a pop in the
    // same cycle never makes room for it.
    push = bus.wr_en & ~full_q;
    pop  = (state_q == ST_IDLE) & ~empty_q;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);

    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        // Read and write never target the same slot here: a pop needs a
        // non-empty FIFO and a push needs a non-full one.
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_done_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q != ST_IDLE) | ~empty_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

`ifdef UART_TX_BUFFER_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
    // A new dropped write outranks a simultaneous clear.
    if (bus.wr_en && full_q) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;
  localparam int DL2   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << DL2;

  logic clk = 1'b0;
  logic reset;
  logic done_auto;
  logic done_force;
  logic auto_en;
  int   done_dly;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of bytes accepted but not yet launched, plus
  // whether the transmitter link is free.
  logic [7:0] exp_q[$];
  bit         link_free = 1'b1;
  bit         in_start  = 1'b0;
  bit         ovf_m     = 1'b0;
  logic [7:0] cur_byte  = 8'h00;
  logic [7:0] last_started = 8'h00;
  int         starts    = 0;
  int         accepted  = 0;

  uart_tx_buffer_if #(.DEPTH_LOG2(DL2), .DATA_WIDTH(DW)) bus ();

  assign bus.tx_done_tick = done_auto | done_force;

  uart_tx_buffer #(.DEPTH_LOG2(DL2), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (bus.busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic manual_drain(input string tag);
    int n = 0;
    while (bus.busy && n < 100) begin
      done_force = 1'b1;
      @(negedge clk);
      done_force = 1'b0;
      repeat (3) @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  // Cycle monitor: after each rising edge, advance the model and compare.
  initial begin
    int occ;
    bit start_due;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        link_free = 1'b1;
        in_start  = 1'b0;
        ovf_m     = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
      end else begin
        occ = exp_q.size();
        start_due = 1'b0;
        if (link_free) begin
          if (occ > 0) begin
            start_due = 1'b1;
            link_free = 1'b0;
            in_start  = 1'b1;
          end
        end else if (in_start) begin
          in_start = 1'b0;
        end else if (bus.tx_done_tick) begin
          link_free = 1'b1;
        end
        chk("tx_start", 32'(bus.tx_start), 32'(start_due));
        if (start_due) begin
          cur_byte = exp_q.pop_front();
          last_started = cur_byte;
          starts++;
        end
        if (bus.wr_en && occ < DEPTH) begin
          exp_q.push_back(bus.wr_data);
          accepted++;
        end
`ifdef UART_TX_BUFFER_OVERFLOW_FLAG_EN
        if (bus.wr_en && occ == DEPTH) ovf_m = 1'b1;
        else if (bus.ovf_clr) ovf_m = 1'b0;
        chk("overflow", 32'(bus.overflow), 32'(ovf_m));
`endif
        chk("count", 32'(bus.count), 32'(exp_q.size()));
        chk("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
        chk("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
        chk("busy", 32'(bus.busy), 32'(!link_free || exp_q.size() != 0));
        if (!link_free) chk("tx_data_hold", 32'(bus.tx_data), 32'(cur_byte));
      end
    end
  end

  // Transmitter stand-in: done_dly cycles after seeing tx_start, pulse done.
  initial begin
    int cnt;
    cnt = 0;
    done_auto = 1'b0;
    forever begin
      @(negedge clk);
      done_auto = 1'b0;
      if (reset) begin
        cnt = 0;
      end else if (bus.tx_start && auto_en) begin
        cnt = done_dly;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) done_auto = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int a0;
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    done_force   = 1'b0;
    auto_en      = 1'b0;
    done_dly     = 20;
`ifdef UART_TX_BUFFER_OVERFLOW_FLAG_EN
    bus.ovf_clr  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("init_empty", 32'(bus.empty), 32'd1);
    chk("init_full", 32'(bus.full), 32'd0);
    chk("init_tx_data", 32'(bus.tx_data), 32'd0);
    reset = 1'b0;

    // 1: single byte, done 20 cycles after start
    auto_en = 1'b1;
    done_dly = 20;
    s0 = starts;
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("t1_no_start_yet", 32'(bus.tx_start), 32'd0);
    chk("t1_count1", 32'(bus.count), 32'd1);
    @(negedge clk);
    chk("t1_start", 32'(bus.tx_start), 32'd1);
    chk("t1_data", 32'(bus.tx_data), 32'hA5);
    wait_idle(60, "t1_drain");
    chk("t1_starts", 32'(starts - s0), 32'd1);
    chk("t1_empty", 32'(bus.empty), 32'd1);

    // 2: fill to 16 while a byte is in flight, then push 0xFF while full
    done_dly = 40;
    s0 = starts;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hEE;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = i[7:0];
      @(negedge clk);
    end
    bus.wr_data = 8'hFF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count16", 32'(bus.count), 32'd16);
`ifdef UART_TX_BUFFER_OVERFLOW_FLAG_EN
    chk("t2_ovf_set", 32'(bus.overflow), 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(bus.overflow), 32'd0);
`endif
    wait_idle(900, "t2_drain");
    chk("t2_starts", 32'(starts - s0), 32'd17);
    chk("t2_last_byte", 32'(last_started), 32'h0F);

    // 3: count held at 5 by simultaneous push and pop
    auto_en = 1'b0;
    s0 = starts;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h30 + i[7:0];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_count5_pre", 32'(bus.count), 32'd5);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h77;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("t3_count5_post", 32'(bus.count), 32'd5);
    chk("t3_pop_start", 32'(bus.tx_start), 32'd1);
    chk("t3_pop_data", 32'(bus.tx_data), 32'h31);
    manual_drain("t3_drain");
    chk("t3_starts", 32'(starts - s0), 32'd7);
    chk("t3_last_byte", 32'(last_started), 32'h77);

    // 4: 40 random bytes in bursts of 10
    auto_en = 1'b1;
    s0 = starts;
    a0 = accepted;
    for (int b = 0; b < 4; b++) begin
      done_dly = $urandom_range(3, 1);
      for (int i = 0; i < 10; i++) begin
        bus.wr_en = 1'b1;
        bus.wr_data = 8'($urandom);
        @(negedge clk);
      end
      bus.wr_en = 1'b0;
      repeat ($urandom_range(50, 30)) @(negedge clk);
    end
    wait_idle(500, "t4_drain");
    chk("t4_accepted", 32'(accepted - a0), 32'd40);
    chk("t4_sent", 32'(starts - s0), 32'd40);

    // 5: spurious done in IDLE (empty) and in START
    auto_en = 1'b0;
    s0 = starts;
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", 32'(bus.busy), 32'd0);
    chk("t5_idle_count", 32'(bus.count), 32'd0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h5A;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("t5_start", 32'(bus.tx_start), 32'd1);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_still_busy", 32'(bus.busy), 32'd1);
    chk("t5_held_data", 32'(bus.tx_data), 32'h5A);
    chk("t5_one_start", 32'(starts - s0), 32'd1);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    @(negedge clk);
    chk("t5_back_idle", 32'(bus.busy), 32'd0);

    // 6: reset during WAIT with 3 queued
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'hC0 + i[7:0];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_queued3", 32'(bus.count), 32'd3);
    reset = 1'b1;
    #1;
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_full", 32'(bus.full), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("t6_rst_tx_data", 32'(bus.tx_data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    auto_en = 1'b1;
    done_dly = 5;
    s0 = starts;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h3C;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_idle(40, "t6_drain");
    chk("t6_one_start", 32'(starts - s0), 32'd1);
    chk("t6_byte", 32'(last_started), 32'h3C);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
